// File: rtl/modexp_operand_port.sv
// Core-side end of the ModExp host word stream: assembles m/e/n/r/t operands
// from LSW-first words and streams the held result back one word per cycle.
module modexp_operand_port #(
    parameter int DATA_WIDTH = 64,
    parameter int WIDTH      = 4096,
    parameter int NWORDS     = WIDTH / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_input,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [63:0]           nprime0_in,
    output logic [WIDTH-1:0]      m_op,
    output logic [WIDTH-1:0]      e_op,
    output logic [WIDTH-1:0]      n_op,
    output logic [WIDTH-1:0]      r_op,
    output logic [WIDTH-1:0]      t_op,
    output logic [63:0]           nprime0_op,
    output logic                  operands_ready,
    output logic                  load_busy,
    output logic                  load_overflow,
    input  logic [WIDTH-1:0]      result,
    input  logic                  result_valid,
    input  logic                  get_result,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    output logic                  res_last,
    output logic                  res_overrun
);
    localparam int CW = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_READY} load_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HELD, R_SEND} res_state_t;

    load_state_t      load_state;
    res_state_t       res_state;
    logic [CW-1:0]    wcnt;
    logic [CW-1:0]    ocnt;
    logic [WIDTH-1:0] res_reg;

    // start_input restarts a load from any state and wins over a coincident word.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_state     <= L_IDLE;
            wcnt           <= '0;
            m_op           <= '0;
            e_op           <= '0;
            n_op           <= '0;
            r_op           <= '0;
            t_op           <= '0;
            nprime0_op     <= '0;
            operands_ready <= 1'b0;
            load_busy      <= 1'b0;
            load_overflow  <= 1'b0;
        end else if (start_input) begin
            load_state     <= L_LOAD;
            wcnt           <= '0;
            nprime0_op     <= nprime0_in;
            operands_ready <= 1'b0;
            load_busy      <= 1'b1;
            load_overflow  <= 1'b0;
        end else begin
            case (load_state)
                L_LOAD: begin
                    if (in_valid) begin
                        m_op[wcnt*DATA_WIDTH +: DATA_WIDTH] <= m_buf;
                        e_op[wcnt*DATA_WIDTH +: DATA_WIDTH] <= e_buf;
                        n_op[wcnt*DATA_WIDTH +: DATA_WIDTH] <= n_buf;
                        r_op[wcnt*DATA_WIDTH +: DATA_WIDTH] <= r_buf;
                        t_op[wcnt*DATA_WIDTH +: DATA_WIDTH] <= t_buf;
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_WORD) begin
                            load_state     <= L_READY;
                            operands_ready <= 1'b1;
                            load_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (in_valid) begin
                        load_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Once R_SEND is entered the full NWORDS burst always completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_state   <= R_IDLE;
            ocnt        <= '0;
            res_reg     <= '0;
            res_out     <= '0;
            res_valid   <= 1'b0;
            res_last    <= 1'b0;
            res_overrun <= 1'b0;
        end else begin
            case (res_state)
                R_IDLE: begin
                    res_out   <= '0;
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                    if (result_valid) begin
                        res_reg   <= result;
                        res_state <= R_HELD;
                    end
                end
                R_HELD: begin
                    res_out   <= '0;
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                    if (result_valid) begin
                        res_reg <= result;
                    end
                    if (get_result) begin
                        res_state <= R_SEND;
                        ocnt      <= '0;
                    end
                end
                R_SEND: begin
                    res_out   <= res_reg[ocnt*DATA_WIDTH +: DATA_WIDTH];
                    res_valid <= 1'b1;
                    res_last  <= (ocnt == LAST_WORD);
                    ocnt      <= ocnt + 1'b1;
                    if (ocnt == LAST_WORD) begin
                        res_state <= R_IDLE;
                    end
                    if (result_valid) begin
                        res_overrun <= 1'b1;
                    end
                end
                default: begin
                    res_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_operand_port.sv
// Directed bench for modexp_operand_port: table-driven operand loads and
// result readouts plus hand-written restart, overflow, collision and reset cases.
module tb_modexp_operand_port;
    localparam int DW = 64;
    localparam int W  = 4096;
    localparam int NW = W / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_input;
    logic          in_valid;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf;
    logic [63:0]   nprime0_in;
    logic [W-1:0]  m_op, e_op, n_op, r_op, t_op;
    logic [63:0]   nprime0_op;
    logic          operands_ready, load_busy, load_overflow;
    logic [W-1:0]  result;
    logic          result_valid, get_result;
    logic [DW-1:0] res_out;
    logic          res_valid, res_last, res_overrun;

    int errors = 0;
    int checks = 0;

    modexp_operand_port #(.DATA_WIDTH(DW), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_input(start_input), .in_valid(in_valid),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0_in(nprime0_in), .m_op(m_op), .e_op(e_op), .n_op(n_op), .r_op(r_op),
        .t_op(t_op), .nprime0_op(nprime0_op), .operands_ready(operands_ready),
        .load_busy(load_busy), .load_overflow(load_overflow), .result(result),
        .result_valid(result_valid), .get_result(get_result), .res_out(res_out),
        .res_valid(res_valid), .res_last(res_last), .res_overrun(res_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] nprime0;
        logic [63:0] m0, e0, n0, r0, t0;
        bit          stall;
        logic [63:0] exp_np, exp_m0, exp_e0, exp_n0, exp_r0, exp_t0;
    } load_vec_t;

    typedef struct {
        logic [63:0] w0;
        logic [63:0] w63;
        logic [63:0] exp_w0;
        logic [63:0] exp_w63;
    } res_vec_t;

    load_vec_t load_tbl[3];
    res_vec_t  res_tbl[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic checkWide(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        bit reported;
        checks++;
        if (act !== want) begin
            errors++;
            reported = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (!reported && act[i*DW +: DW] !== want[i*DW +: DW]) begin
                    $display("[TB] FAIL %s word %0d: got %0h expected %0h",
                             name, i, act[i*DW +: DW], want[i*DW +: DW]);
                    reported = 1'b1;
                end
            end
        end
    endtask

    task automatic driveWord(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                             input logic [63:0] r, input logic [63:0] t);
        m_buf = m; e_buf = e; n_buf = n; r_buf = r; t_buf = t;
    endtask

    // Full load whose only non-zero words are word 0 of each operand.
    task automatic applyStimulus(input load_vec_t v, input int idx);
        logic [W-1:0] want;
        start_input = 1'b1;
        nprime0_in  = v.nprime0;
        in_valid    = 1'b0;
        tick();
        start_input = 1'b0;
        checkOutput($sformatf("vec%0d busy after start", idx), 64'(load_busy), 64'd1);
        checkOutput($sformatf("vec%0d ready cleared", idx), 64'(operands_ready), 64'd0);
        for (int i = 0; i < NW; i++) begin
            if (v.stall) begin
                in_valid = 1'b0;
                tick();
                if (operands_ready !== 1'b0) begin
                    checkOutput($sformatf("vec%0d early ready stall %0d", idx, i), 64'(operands_ready), 64'd0);
                end
            end
            in_valid = 1'b1;
            if (i == 0) driveWord(v.m0, v.e0, v.n0, v.r0, v.t0);
            else        driveWord('0, '0, '0, '0, '0);
            tick();
            if (i < NW - 1 && operands_ready !== 1'b0) begin
                checkOutput($sformatf("vec%0d early ready word %0d", idx, i), 64'(operands_ready), 64'd0);
            end
        end
        in_valid = 1'b0;
        checkOutput($sformatf("vec%0d ready", idx), 64'(operands_ready), 64'd1);
        checkOutput($sformatf("vec%0d busy done", idx), 64'(load_busy), 64'd0);
        checkOutput($sformatf("vec%0d overflow", idx), 64'(load_overflow), 64'd0);
        checkOutput($sformatf("vec%0d nprime0", idx), nprime0_op, v.exp_np);
        want = '0; want[63:0] = v.exp_m0; checkWide($sformatf("vec%0d m_op", idx), m_op, want);
        want = '0; want[63:0] = v.exp_e0; checkWide($sformatf("vec%0d e_op", idx), e_op, want);
        want = '0; want[63:0] = v.exp_n0; checkWide($sformatf("vec%0d n_op", idx), n_op, want);
        want = '0; want[63:0] = v.exp_r0; checkWide($sformatf("vec%0d r_op", idx), r_op, want);
        want = '0; want[63:0] = v.exp_t0; checkWide($sformatf("vec%0d t_op", idx), t_op, want);
    endtask

    // Called right after the edge on which the result FSM entered R_SEND.
    task automatic readStream(input string name, input logic [W-1:0] want, input int pulse_at);
        for (int k = 0; k < NW; k++) begin
            if (k == pulse_at) begin
                result_valid = 1'b1;
                result       = ~want;
            end
            tick();
            result_valid = 1'b0;
            checkOutput($sformatf("%s res_valid %0d", name, k), 64'(res_valid), 64'd1);
            checkOutput($sformatf("%s res_out %0d", name, k), res_out, want[k*DW +: DW]);
            checkOutput($sformatf("%s res_last %0d", name, k), 64'(res_last), (k == NW - 1) ? 64'd1 : 64'd0);
        end
        tick();
        checkOutput($sformatf("%s res_valid after", name), 64'(res_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] want_m, want_e, want_r;

        load_tbl[0] = '{64'h1B, 64'd8, 64'd13, 64'd77, 64'd0, 64'd0, 1'b0,
                        64'h1B, 64'd8, 64'd13, 64'd77, 64'd0, 64'd0};
        load_tbl[1] = '{64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10001, 64'hC35, 64'h5, 64'h9, 1'b0,
                        64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10001, 64'hC35, 64'h5, 64'h9};
        load_tbl[2] = '{64'h1B, 64'd8, 64'd13, 64'd77, 64'd0, 64'd0, 1'b1,
                        64'h1B, 64'd8, 64'd13, 64'd77, 64'd0, 64'd0};
        res_tbl[0]  = '{64'd50, 64'd0, 64'd50, 64'd0};
        res_tbl[1]  = '{64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001,
                        64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001};

        reset = 1'b1; start_input = 1'b0; in_valid = 1'b0; nprime0_in = '0;
        driveWord('0, '0, '0, '0, '0);
        result = '0; result_valid = 1'b0; get_result = 1'b0;
        tick(); tick();
        checkOutput("reset busy", 64'(load_busy), 64'd0);
        checkOutput("reset ready", 64'(operands_ready), 64'd0);
        checkOutput("reset overflow", 64'(load_overflow), 64'd0);
        checkOutput("reset nprime0", nprime0_op, 64'd0);
        checkWide("reset m_op", m_op, '0);
        checkOutput("reset res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset res_last", 64'(res_last), 64'd0);
        checkOutput("reset res_out", res_out, 64'd0);
        checkOutput("reset overrun", 64'(res_overrun), 64'd0);
        reset = 1'b0;

        get_result = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("idle get_result %0d", i), 64'(res_valid), 64'd0);
        end
        get_result = 1'b0;

        for (int v = 0; v < 3; v++) applyStimulus(load_tbl[v], v);

        // Restart after 10 words; the word coinciding with start_input is dropped.
        start_input = 1'b1; nprime0_in = 64'h11; tick();
        start_input = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            driveWord(64'hA0 + 64'(i), 64'hA0, 64'hA0, 64'hA0, 64'hA0);
            tick();
        end
        start_input = 1'b1; nprime0_in = 64'h22; driveWord(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
        tick();
        start_input = 1'b0;
        checkOutput("restart nprime0", nprime0_op, 64'h22);
        checkOutput("restart busy", 64'(load_busy), 64'd1);
        checkOutput("restart ready", 64'(operands_ready), 64'd0);
        want_m = '0; want_e = '0;
        for (int i = 0; i < NW; i++) begin
            want_m[i*DW +: DW] = 64'(i);
            want_e[i*DW +: DW] = 64'(i) + 64'd1;
            driveWord(64'(i), 64'(i) + 64'd1, 64'(i), 64'(i), 64'(i));
            tick();
            if (i == 53 || (i < NW - 1 && operands_ready !== 1'b0)) begin
                checkOutput($sformatf("restart early ready %0d", i), 64'(operands_ready), 64'd0);
            end
        end
        in_valid = 1'b0;
        checkOutput("restart ready after 64", 64'(operands_ready), 64'd1);
        checkWide("restart m_op", m_op, want_m);
        checkWide("restart e_op", e_op, want_e);

        in_valid = 1'b1; driveWord(64'hBAD, 64'hBAD, 64'hBAD, 64'hBAD, 64'hBAD);
        tick();
        in_valid = 1'b0;
        checkOutput("overflow set", 64'(load_overflow), 64'd1);
        checkOutput("overflow ready held", 64'(operands_ready), 64'd1);
        checkWide("overflow m_op unchanged", m_op, want_m);

        // New load clears overflow; reset lands at word 30.
        start_input = 1'b1; nprime0_in = 64'h33; tick();
        start_input = 1'b0;
        checkOutput("overflow cleared", 64'(load_overflow), 64'd0);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; driveWord(64'h55, 64'h55, 64'h55, 64'h55, 64'h55);
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; in_valid = 1'b0;
        checkOutput("midload reset busy", 64'(load_busy), 64'd0);
        checkOutput("midload reset ready", 64'(operands_ready), 64'd0);
        checkOutput("midload reset nprime0", nprime0_op, 64'd0);
        checkWide("midload reset m_op", m_op, '0);
        checkWide("midload reset t_op", t_op, '0);

        for (int v = 0; v < 2; v++) begin
            want_r = '0;
            want_r[63:0] = res_tbl[v].exp_w0;
            want_r[W-1 -: 64] = res_tbl[v].exp_w63;
            result = '0; result[63:0] = res_tbl[v].w0; result[W-1 -: 64] = res_tbl[v].w63;
            result_valid = 1'b1; tick();
            result_valid = 1'b0; get_result = 1'b1; tick();
            get_result = 1'b0;
            readStream($sformatf("res%0d", v), want_r, -1);
        end
        checkOutput("no overrun yet", 64'(res_overrun), 64'd0);

        // Capture and request together, then overrun mid-stream.
        want_r = '0;
        want_r[63:0] = 64'h77; want_r[127:64] = 64'hAB; want_r[W-1 -: 64] = 64'hCAFE;
        result = want_r; result_valid = 1'b1; get_result = 1'b1;
        tick();
        result_valid = 1'b0;
        checkOutput("collide capture no valid", 64'(res_valid), 64'd0);
        tick();
        get_result = 1'b0;
        checkOutput("collide send state no valid", 64'(res_valid), 64'd0);
        readStream("collide", want_r, 3);
        checkOutput("overrun set", 64'(res_overrun), 64'd1);

        // Reset at word 5 of a readout.
        result = '0; result[63:0] = 64'h99; result_valid = 1'b1; tick();
        result_valid = 1'b0; get_result = 1'b1; tick();
        get_result = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checkOutput("midsend word5 valid", 64'(res_valid), 64'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("midsend reset valid", 64'(res_valid), 64'd0);
        checkOutput("midsend reset out", res_out, 64'd0);
        checkOutput("midsend reset last", 64'(res_last), 64'd0);
        checkOutput("midsend reset overrun", 64'(res_overrun), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("post reset valid %0d", k), 64'(res_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modexp_operand_port.md
Name: modexp_operand_port

Overview:
- Core-side end of the host operand/result word stream for the ModExp engine.
- Deserialises DATA_WIDTH-bit words, least significant word first, into WIDTH-bit m, e, n, r and t operand registers, and captures nprime0.
- Latches the core's WIDTH-bit result and serialises it back to the host one word per cycle on request.
- Sits between the host stream interface and the ModExp datapath.

Parameters:
- DATA_WIDTH, 64, bits per stream word.
- WIDTH, 4096, operand/result width; must be a multiple of DATA_WIDTH.
- NWORDS, WIDTH/DATA_WIDTH (64), words per operand. Derived; not to be overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start_input  in  1  one-cycle pulse; begins an operand load.
- in_valid  in  1  the words on the five *_buf inputs are valid this cycle.
- m_buf, e_buf, n_buf, r_buf, t_buf  in  DATA_WIDTH each  operand words.
- nprime0_in  in  64  sampled on start_input.
- m_op, e_op, n_op, r_op, t_op  out  WIDTH each  assembled operands.
- nprime0_op  out  64  captured nprime0.
- operands_ready  out  1  all NWORDS words loaded.
- load_busy  out  1  a load is in progress.
- load_overflow  out  1  sticky; a word arrived while not loading.
- result  in  WIDTH  result from the core.
- result_valid  in  1  one-cycle pulse; result is valid.
- get_result  in  1  level; host requests result readout.
- res_out  out  DATA_WIDTH  result word.
- res_valid  out  1  res_out is valid.
- res_last  out  1  marks the final result word.
- res_overrun  out  1  sticky; a result arrived while readout was busy.

Behaviour:
- Reset: all outputs are 0; every operand register, nprime0_op and the internal result register are 0; both FSMs go to their idle state.
- All outputs are registered. Word counters are $clog2(NWORDS+1) bits wide.
- Load FSM states: L_IDLE, L_LOAD, L_READY.
  - L_IDLE / L_READY, start_input=1: go to L_LOAD; wcnt=0; nprime0_op<=nprime0_in; operands_ready<=0; load_busy<=1; load_overflow<=0.
  - L_LOAD, in_valid=1: slice [wcnt*DATA_WIDTH +: DATA_WIDTH] of each operand register <= the matching *_buf; wcnt++.
  - L_LOAD, in_valid=0: stall; no change.
  - Last word (in_valid with wcnt==NWORDS-1): go to L_READY; operands_ready=1 and load_busy=0 from the next cycle. Latency from last word to ready is 1 cycle.
  - start_input during L_LOAD: restart; wcnt=0; nprime0 is recaptured. Stale upper words persist until overwritten.
  - start_input together with in_valid: start_input wins; the word is dropped.
  - in_valid in L_IDLE or L_READY without start_input: data is ignored; load_overflow<=1.
  - operands_ready holds high in L_READY until the next start_input.
- Result FSM states: R_IDLE, R_HELD, R_SEND.
  - R_IDLE, result_valid=1: result register <= result; go to R_HELD.
  - R_HELD, get_result=1: go to R_SEND; ocnt=0.
  - R_SEND, each cycle: res_out <= word ocnt; res_valid<=1; res_last<=(ocnt==NWORDS-1); ocnt++.
  - R_SEND, after the last word: go to R_IDLE; res_valid=0 the following cycle.
  - Readout is exactly NWORDS consecutive cycles. get_result deassertion mid-send does not pause it.
  - get_result in R_IDLE: no action; no words are emitted until a result is held.
  - result_valid and get_result in the same R_IDLE cycle: capture only. The send FSM enters R_SEND on the next cycle if get_result is still high.
  - result_valid in R_HELD: replaces the held value; no flag.
  - result_valid in R_SEND: ignored; res_overrun<=1. This flag is cleared only by reset.
- The load FSM and result FSM run independently. A new load may proceed during result readout.
- Reset asserted mid-load or mid-send: immediate return to reset values on the next edge; no partial words are emitted.

Test Plan:
- Basic load: reset; start_input with nprime0_in=0x1B; 64 in_valid cycles, word0 m=8, e=13, n=77, all other words 0 -> operands_ready rises 1 cycle after the last word; m_op=8, e_op=13, n_op=77, nprime0_op=0x1B; load_overflow=0.
- Stalled load: the same 64 words with in_valid low on alternate cycles -> identical operands; operands_ready rises after the 64th valid word, not earlier.
- Restart and overflow:
  - start_input after 10 words, then a full 64-word load with word i = i -> m_op word i = i for all i; operands_ready rises 1 cycle after the 64th post-restart word, not after 54.
  - Then one extra in_valid -> load_overflow=1 and operands unchanged.
- Result readout: result_valid with result=50, then get_result=1 -> 64 consecutive res_valid cycles; word0=50, words 1..63=0; res_last only on the 64th word.
- Result collisions:
  - result_valid and get_result in the same cycle -> capture, then readout starts the next cycle.
  - result_valid during R_SEND -> res_overrun=1 and the stream completes with the original data.
- Reset mid-operation: reset at word 30 of a load and at word 5 of a readout -> all outputs 0 the next cycle; res_valid stays 0 afterwards.
